wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter that shares the single memory bus between instruction fetch (M0) and the memory stage Wishbone master (M1).
- Sits between the core and the memory/peripheral interconnect.
- Registered round-robin grant: a bus cycle is held until ack, then ownership is re-arbitrated.
- Non-granted masters see ack=0, which stalls them.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 255, cycles to wait for slave ack before forced termination (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_addr  in  ADDR_W  fetch address
- m0_data_out  in  DATA_W  fetch write data (unused by fetch, routed anyway)
- m0_data_in  out  DATA_W  read data to fetch
- m0_we  in  1  fetch write enable
- m0_stb  in  1  fetch strobe
- m0_cyc  in  1  fetch cycle request
- m0_ack  out  1  ack to fetch
- m1_addr, m1_data_out, m1_data_in, m1_we, m1_stb, m1_cyc, m1_ack: same as M0, for the memory stage
- s_addr  out  ADDR_W  slave address
- s_data_out  out  DATA_W  slave write data
- s_data_in  in  DATA_W  slave read data
- s_we  out  1  slave write enable
- s_stb  out  1  slave strobe
- s_cyc  out  1  slave cycle
- s_ack  in  1  slave ack
- gnt  out  2  one-hot current owner: bit0 = M0, bit1 = M1; 00 when idle

Behaviour:
- **Clocking and reset.** Single clock domain. Reset is asynchronous and active-low.
  - On reset: state IDLE, gnt=00, last_served=M1 (so M0 wins the first tie), timeout counter 0.
  - All s_* outputs and m*_ack are 0; m*_data_in may be any value while ack=0.
- **States:**
  - IDLE
  - OWN_M0
  - OWN_M1
- **Transitions:**
  - From IDLE: if exactly one of m0_cyc/m1_cyc is high, go to that owner at the next edge. If both are high, go to the master that is not last_served.
  - From OWN_x with s_ack=1: the transaction completes this cycle and last_served<=x. At the same edge, re-arbitrate using current m*_cyc values (same rule as IDLE, with the updated last_served). If no requester, go to IDLE. This allows back-to-back transactions with zero idle cycles.
  - From OWN_x with mx_cyc=0 (owner abort, no ack): go to IDLE at the next edge. last_served is unchanged.
- **Datapath (combinational from registered state):**
  - s_addr, s_data_out, s_we, s_stb, s_cyc are the owner's signals.
  - In IDLE all s_* outputs are 0.
  - mx_ack = s_ack & (owner==x).
  - m0_data_in and m1_data_in are both driven from s_data_in.
- **Latency:** a request raised in cycle N from IDLE is presented to the slave in cycle N+1. The slave ack passes through to the master in the same cycle.
- **Simultaneous events:**
  - If s_ack arrives in the same cycle the owner drops cyc, the ack is delivered and the transaction counts as completed.
  - A master that keeps cyc high after its ack is treated as a new request.
  - An s_ack seen in IDLE is ignored.
- **Reset mid-transaction:** the transaction is abandoned immediately and all outputs return to their reset values asynchronously.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- **Defined:**
  - Adds ports m0_err, m1_err, out, 1 bit each, plus a counter that clears on every grant change.
  - If the owner waits TIMEOUT_CYCLES cycles with no s_ack, mx_err pulses for 1 cycle and s_cyc/s_stb drop.
  - The state then re-arbitrates exactly as on ack, and last_served<=owner.
- **Undefined:** no err ports and no counter; the arbiter waits for s_ack indefinitely.

Decomposition:
- Shared package wb_pkg holds:
  - state encoding constants IDLE/OWN_M0/OWN_M1
  - master index constants M0=0, M1=1
  - the default address/data widths
- One sub-module, wb_rr_pick: a pure combinational 2-way round-robin picker taking req[1:0] and last_served, returning next owner and a valid flag. It is reused by the IDLE and post-ack paths.

Test Plan:
- M0 only, m0_addr=0x0000_0010, slave acks 2 cycles after stb -> s_addr=0x10 from cycle N+1, m0_ack high for exactly 1 cycle, m1_ack stays 0, gnt=01 then 00.
- M0 and M1 request in the same cycle from reset -> M0 granted first. On ack, M1 is granted at that edge with no idle cycle. gnt sequence 01, 10, 00.
- Both hold cyc continuously for 6 transactions -> strict alternation M0, M1, M0, M1, M0, M1.
- M1 write, addr=0x100, data=0xDEAD_BEEF, held while M0 also requests -> s_we=1, s_data_out=0xDEADBEEF. M0 is stalled (m0_ack=0) until M1 is acked.
- Owner drops cyc before ack, then s_ack pulses while IDLE -> no master sees ack, gnt=00.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks M0 -> m0_err pulses on cycle 8 of ownership, s_cyc=0, and a pending M1 is granted next.
- rst_n asserted mid-transaction -> all outputs 0 immediately; after release, arbitration restarts from IDLE.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: state encoding,
// master indices and default bus widths.
package wb_pkg;

    localparam int unsigned WB_ADDR_W = 32;
    localparam int unsigned WB_DATA_W = 32;

    // One-hot owner encoding so the grant vector is the state itself
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OWN_M0 = 2'b01,
        OWN_M1 = 2'b10
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the slave.
// Error strobes exist only when WB_ARB_TIMEOUT_EN is defined.
interface wb_arbiter_if
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_W = WB_ADDR_W,
    parameter int unsigned DATA_W = WB_DATA_W
);
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_data_out;
    logic [DATA_W-1:0] m0_data_in;
    logic              m0_we;
    logic              m0_stb;
    logic              m0_cyc;
    logic              m0_ack;

    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_data_out;
    logic [DATA_W-1:0] m1_data_in;
    logic              m1_we;
    logic              m1_stb;
    logic              m1_cyc;
    logic              m1_ack;

    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_data_out;
    logic [DATA_W-1:0] s_data_in;
    logic              s_we;
    logic              s_stb;
    logic              s_cyc;
    logic              s_ack;
`ifdef WB_ARB_TIMEOUT_EN
    logic              m0_err;
    logic              m1_err;
`endif

    // Arbiter view: a slave to M0/M1, a master toward the memory bus
    modport slave (
        input  m0_addr, m0_data_out, m0_we, m0_stb, m0_cyc,
        output m0_data_in, m0_ack,
        input  m1_addr, m1_data_out, m1_we, m1_stb, m1_cyc,
        output m1_data_in, m1_ack,
        output s_addr, s_data_out, s_we, s_stb, s_cyc,
        input  s_data_in, s_ack
`ifdef WB_ARB_TIMEOUT_EN
        , output m0_err, m1_err
`endif
    );

    // Environment view: drives the masters' requests and the slave response
    modport master (
        output m0_addr, m0_data_out, m0_we, m0_stb, m0_cyc,
        input  m0_data_in, m0_ack,
        output m1_addr, m1_data_out, m1_we, m1_stb, m1_cyc,
        input  m1_data_in, m1_ack,
        input  s_addr, s_data_out, s_we, s_stb, s_cyc,
        output s_data_in, s_ack
`ifdef WB_ARB_TIMEOUT_EN
        , input m0_err, m1_err
`endif
    );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the master that was not
// served last wins.
module wb_rr_pick (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic       owner,
    output logic       valid
);

    always_comb begin
        valid = |req;
        owner = (req == 2'b11) ? ~last_served : req[1];
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter with registered round-robin
// grant. Define WB_ARB_TIMEOUT_EN to add the slave-ack timeout and err strobes.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_W = WB_ADDR_W,
    parameter int unsigned DATA_W = WB_DATA_W
`ifdef WB_ARB_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus,
    output logic [1:0]   gnt
);

    state_e state_q, state_d;
    logic   last_served_q, last_served_d;
    logic   timeout_c;
    logic   complete_c;
    logic   cur_owner_c;
    logic   owner_cyc_c;
    logic   pick_last_c;
    logic   pick_owner;
    logic   pick_valid;

    assign cur_owner_c = (state_q == OWN_M1) ? M1 : M0;
    assign owner_cyc_c = (state_q == OWN_M1) ? bus.m1_cyc : bus.m0_cyc;
    assign complete_c  = (state_q != IDLE) && (bus.s_ack || timeout_c);
    // A completing owner is treated as already served when re-arbitrating
    assign pick_last_c = complete_c ? cur_owner_c : last_served_q;

    wb_rr_pick u_pick (
        .req         ({bus.m1_cyc, bus.m0_cyc}),
        .last_served (pick_last_c),
        .owner       (pick_owner),
        .valid       (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_served_q <= M1;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) state_d = pick_owner ? OWN_M1 : OWN_M0;
            end
            OWN_M0, OWN_M1: begin
                if (complete_c) begin
                    last_served_d = cur_owner_c;
                    state_d       = !pick_valid ? IDLE : (pick_owner ? OWN_M1 : OWN_M0);
                end else if (!owner_cyc_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts cycles of the current transaction; restarts on any completion or grant change
    always_comb begin
        cnt_d = '0;
        if ((state_q != IDLE) && !complete_c && (state_d == state_q))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign timeout_c = (state_q != IDLE) && !bus.s_ack &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_c = 1'b0;
`endif

    always_comb begin
        bus.s_addr     = '0;
        bus.s_data_out = '0;
        bus.s_we       = 1'b0;
        bus.s_stb      = 1'b0;
        bus.s_cyc      = 1'b0;
        bus.m0_ack     = 1'b0;
        bus.m1_ack     = 1'b0;
        bus.m0_data_in = DATA_W'(bus.s_data_in);
        bus.m1_data_in = DATA_W'(bus.s_data_in);
        gnt            = 2'(state_q);
`ifdef WB_ARB_TIMEOUT_EN
        bus.m0_err     = timeout_c && (state_q == OWN_M0);
        bus.m1_err     = timeout_c && (state_q == OWN_M1);
`endif
        unique case (state_q)
            OWN_M0: begin
                bus.s_addr     = ADDR_W'(bus.m0_addr);
                bus.s_data_out = DATA_W'(bus.m0_data_out);
                bus.s_we       = bus.m0_we;
                bus.s_stb      = bus.m0_stb && !timeout_c;
                bus.s_cyc      = bus.m0_cyc && !timeout_c;
                bus.m0_ack     = bus.s_ack;
            end
            OWN_M1: begin
                bus.s_addr     = ADDR_W'(bus.m1_addr);
                bus.s_data_out = DATA_W'(bus.m1_data_out);
                bus.s_we       = bus.m1_we;
                bus.s_stb      = bus.m1_stb && !timeout_c;
                bus.s_cyc      = bus.m1_cyc && !timeout_c;
                bus.m1_ack     = bus.s_ack;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; define WB_ARB_TIMEOUT_EN to
// exercise the timeout path with TIMEOUT_CYCLES=8.
module tb_wb_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] gnt;
    int         errors = 0;
    int         checks = 0;

    wb_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef WB_ARB_TIMEOUT_EN
    wb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .gnt(gnt));
`else
    wb_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .gnt(gnt));
`endif

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.m0_addr = '0; bus.m0_data_out = '0; bus.m0_we = 0; bus.m0_stb = 0; bus.m0_cyc = 0;
        bus.m1_addr = '0; bus.m1_data_out = '0; bus.m1_we = 0; bus.m1_stb = 0; bus.m1_cyc = 0;
        bus.s_data_in = '0; bus.s_ack = 0;
    endtask

    task automatic do_reset;
        rst_n = 0;
        idle_inputs();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        bus.m0_cyc = 1; bus.m0_stb = 1; bus.m0_addr = 32'h44; bus.s_ack = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
        checks++; if (bus.s_cyc !== 1'b0 || bus.s_stb !== 1'b0) begin errors++; $display("FAIL reset_s_cyc_stb got=%b%b exp=00", bus.s_cyc, bus.s_stb); end
        checks++; if (bus.s_addr !== 32'h0) begin errors++; $display("FAIL reset_s_addr got=%h exp=0", bus.s_addr); end
        checks++; if (bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0) begin errors++; $display("FAIL reset_acks got=%b%b exp=00", bus.m0_ack, bus.m1_ack); end
        idle_inputs();
        rst_n = 1;
        tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_release_gnt got=%b exp=00", gnt); end
    endtask

    task automatic test_m0_single;
        bus.m0_addr = 32'h0000_0010; bus.m0_cyc = 1; bus.m0_stb = 1;
        #1;
        checks++; if (gnt !== 2'b00 || bus.s_cyc !== 1'b0) begin errors++; $display("FAIL single_req_cycle got gnt=%b s_cyc=%b exp 00/0", gnt, bus.s_cyc); end
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got=%b exp=01", gnt); end
        checks++; if (bus.s_addr !== 32'h10 || bus.s_cyc !== 1'b1 || bus.s_stb !== 1'b1) begin errors++; $display("FAIL single_slave_side got addr=%h cyc=%b stb=%b exp 10/1/1", bus.s_addr, bus.s_cyc, bus.s_stb); end
        checks++; if (bus.m0_ack !== 1'b0) begin errors++; $display("FAIL single_no_early_ack got=%b exp=0", bus.m0_ack); end
        tick();
        checks++; if (gnt !== 2'b01 || bus.m0_ack !== 1'b0) begin errors++; $display("FAIL single_wait got gnt=%b ack=%b exp 01/0", gnt, bus.m0_ack); end
        tick();
        bus.s_ack = 1; bus.s_data_in = 32'hCAFE_0010; bus.m0_cyc = 0; bus.m0_stb = 0;
        #1;
        checks++; if (bus.m0_ack !== 1'b1 || bus.m1_ack !== 1'b0) begin errors++; $display("FAIL single_ack got m0=%b m1=%b exp 1/0", bus.m0_ack, bus.m1_ack); end
        checks++; if (bus.m0_data_in !== 32'hCAFE_0010) begin errors++; $display("FAIL single_rdata got=%h exp=cafe0010", bus.m0_data_in); end
        tick();
        bus.s_ack = 0;
        #1;
        checks++; if (gnt !== 2'b00 || bus.m0_ack !== 1'b0 || bus.s_cyc !== 1'b0) begin errors++; $display("FAIL single_release got gnt=%b ack=%b cyc=%b exp 00/0/0", gnt, bus.m0_ack, bus.s_cyc); end
    endtask

    task automatic test_simultaneous;
        do_reset();
        bus.m0_addr = 32'hA0; bus.m1_addr = 32'hB0;
        bus.m0_cyc = 1; bus.m0_stb = 1; bus.m1_cyc = 1; bus.m1_stb = 1;
        tick();
        checks++; if (gnt !== 2'b01 || bus.s_addr !== 32'hA0) begin errors++; $display("FAIL sim_first got gnt=%b addr=%h exp 01/a0", gnt, bus.s_addr); end
        bus.s_ack = 1; bus.m0_cyc = 0; bus.m0_stb = 0;
        #1;
        checks++; if (bus.m0_ack !== 1'b1 || bus.m1_ack !== 1'b0) begin errors++; $display("FAIL sim_ack0 got m0=%b m1=%b exp 1/0", bus.m0_ack, bus.m1_ack); end
        tick();
        bus.s_ack = 0;
        #1;
        checks++; if (gnt !== 2'b10 || bus.s_addr !== 32'hB0) begin errors++; $display("FAIL sim_second got gnt=%b addr=%h exp 10/b0", gnt, bus.s_addr); end
        bus.s_ack = 1; bus.m1_cyc = 0; bus.m1_stb = 0;
        #1;
        checks++; if (bus.m1_ack !== 1'b1 || bus.m0_ack !== 1'b0) begin errors++; $display("FAIL sim_ack1 got m0=%b m1=%b exp 0/1", bus.m0_ack, bus.m1_ack); end
        tick();
        bus.s_ack = 0;
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL sim_idle got=%b exp=00", gnt); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_gnt;
        bus.m0_cyc = 1; bus.m0_stb = 1; bus.m1_cyc = 1; bus.m1_stb = 1;
        tick();
        bus.s_ack = 1;
        for (int i = 0; i < 6; i++) begin
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
            if (i == 5) begin bus.m0_cyc = 0; bus.m1_cyc = 0; bus.m0_stb = 0; bus.m1_stb = 0; end
            #1;
            checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL b2b_gnt[%0d] got=%b exp=%b", i, gnt, exp_gnt); end
            checks++; if ({bus.m1_ack, bus.m0_ack} !== exp_gnt) begin errors++; $display("FAIL b2b_ack[%0d] got=%b exp=%b", i, {bus.m1_ack, bus.m0_ack}, exp_gnt); end
            tick();
        end
        bus.s_ack = 0;
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL b2b_idle got=%b exp=00", gnt); end
    endtask

    task automatic test_m1_write;
        bus.m1_addr = 32'h100; bus.m1_data_out = 32'hDEAD_BEEF; bus.m1_we = 1;
        bus.m1_cyc = 1; bus.m1_stb = 1;
        tick();
        bus.m0_addr = 32'h20; bus.m0_cyc = 1; bus.m0_stb = 1;
        #1;
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL wr_gnt got=%b exp=10", gnt); end
        checks++; if (bus.s_we !== 1'b1 || bus.s_data_out !== 32'hDEAD_BEEF || bus.s_addr !== 32'h100) begin errors++; $display("FAIL wr_bus got we=%b data=%h addr=%h exp 1/deadbeef/100", bus.s_we, bus.s_data_out, bus.s_addr); end
        tick();
        checks++; if (gnt !== 2'b10 || bus.m0_ack !== 1'b0) begin errors++; $display("FAIL wr_m0_stalled got gnt=%b m0_ack=%b exp 10/0", gnt, bus.m0_ack); end
        bus.s_ack = 1; bus.m1_cyc = 0; bus.m1_stb = 0; bus.m1_we = 0;
        #1;
        checks++; if (bus.m1_ack !== 1'b1 || bus.m0_ack !== 1'b0) begin errors++; $display("FAIL wr_ack got m0=%b m1=%b exp 0/1", bus.m0_ack, bus.m1_ack); end
        tick();
        bus.s_ack = 0;
        #1;
        checks++; if (gnt !== 2'b01 || bus.s_we !== 1'b0 || bus.s_addr !== 32'h20) begin errors++; $display("FAIL wr_then_m0 got gnt=%b we=%b addr=%h exp 01/0/20", gnt, bus.s_we, bus.s_addr); end
        bus.s_ack = 1; bus.m0_cyc = 0; bus.m0_stb = 0;
        tick();
        bus.s_ack = 0;
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL wr_idle got=%b exp=00", gnt); end
    endtask

    task automatic test_abort;
        bus.m0_cyc = 1; bus.m0_stb = 1;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL abort_gnt got=%b exp=01", gnt); end
        bus.m0_cyc = 0; bus.m0_stb = 0;
        tick();
        bus.s_ack = 1;
        #1;
        checks++; if (gnt !== 2'b00 || bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0) begin errors++; $display("FAIL abort_idle_ack got gnt=%b acks=%b%b exp 00/00", gnt, bus.m1_ack, bus.m0_ack); end
        tick();
        bus.s_ack = 0;
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL abort_stay_idle got=%b exp=00", gnt); end
        // last completion was M0 and the abort leaves it unchanged, so M1 wins the tie
        bus.m0_cyc = 1; bus.m1_cyc = 1;
        tick();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL abort_tie got=%b exp=10", gnt); end
        bus.s_ack = 1; bus.m0_cyc = 0; bus.m1_cyc = 0;
        tick();
        bus.s_ack = 0;
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout;
        do_reset();
        bus.m0_cyc = 1; bus.m0_stb = 1;
        tick();
        bus.m1_cyc = 1; bus.m1_stb = 1;
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (c < 8) begin
                checks++; if (bus.m0_err !== 1'b0 || gnt !== 2'b01) begin errors++; $display("FAIL to_wait[%0d] got err=%b gnt=%b exp 0/01", c, bus.m0_err, gnt); end
            end else begin
                checks++; if (bus.m0_err !== 1'b1 || bus.s_cyc !== 1'b0 || bus.s_stb !== 1'b0) begin errors++; $display("FAIL to_fire got err=%b cyc=%b stb=%b exp 1/0/0", bus.m0_err, bus.s_cyc, bus.s_stb); end
                bus.m0_cyc = 0; bus.m0_stb = 0;
            end
            tick();
        end
        #1;
        checks++; if (gnt !== 2'b10 || bus.m0_err !== 1'b0 || bus.m1_err !== 1'b0) begin errors++; $display("FAIL to_next got gnt=%b err=%b%b exp 10/00", gnt, bus.m1_err, bus.m0_err); end
        bus.s_ack = 1; bus.m1_cyc = 0; bus.m1_stb = 0;
        tick();
        bus.s_ack = 0;
    endtask
`else
    task automatic test_no_timeout;
        bus.m0_cyc = 1; bus.m0_stb = 1;
        repeat (40) tick();
        checks++; if (gnt !== 2'b01 || bus.s_cyc !== 1'b1) begin errors++; $display("FAIL hold_no_ack got gnt=%b cyc=%b exp 01/1", gnt, bus.s_cyc); end
        bus.s_ack = 1; bus.m0_cyc = 0; bus.m0_stb = 0;
        tick();
        bus.s_ack = 0;
    endtask
`endif

    task automatic test_reset_mid;
        bus.m0_addr = 32'h55; bus.m0_cyc = 1; bus.m0_stb = 1;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rmid_gnt got=%b exp=01", gnt); end
        #2;
        bus.s_ack = 1;
        rst_n = 0;
        #1;
        checks++; if (gnt !== 2'b00 || bus.s_cyc !== 1'b0 || bus.s_stb !== 1'b0 || bus.s_addr !== 32'h0) begin errors++; $display("FAIL rmid_async got gnt=%b cyc=%b stb=%b addr=%h exp 00/0/0/0", gnt, bus.s_cyc, bus.s_stb, bus.s_addr); end
        checks++; if (bus.m0_ack !== 1'b0) begin errors++; $display("FAIL rmid_ack got=%b exp=0", bus.m0_ack); end
        tick();
        bus.s_ack = 0;
        rst_n = 1;
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rmid_release got=%b exp=00", gnt); end
        tick();
        checks++; if (gnt !== 2'b01 || bus.s_addr !== 32'h55) begin errors++; $display("FAIL rmid_restart got gnt=%b addr=%h exp 01/55", gnt, bus.s_addr); end
        bus.s_ack = 1; bus.m0_cyc = 0; bus.m0_stb = 0;
        tick();
        bus.s_ack = 0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_m0_single();
        test_simultaneous();
        test_back_to_back();
        test_m1_write();
        test_abort();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
